// File: rtl/nand_tester_pkg.sv
// Shared types and the per-step vector generator for the quad NAND self-test sequencer.
package nand_tester_pkg;

    localparam int NUM_GATES = 4;
    localparam int ERR_W     = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [NUM_GATES-1:0] a;
        logic [NUM_GATES-1:0] b;
        logic [NUM_GATES-1:0] y;
    } vec_t;

    // Gate i gets combo (step+i) mod 4, so neighbouring gates never share an input pattern.
    function automatic vec_t vec_for_step(input logic [1:0] step);
        vec_t       v;
        logic [1:0] c;
        v = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            c      = step + 2'(i);
            v.a[i] = c[1];
            v.b[i] = c[0];
        end
        v.y = ~(v.a & v.b);
        return v;
    endfunction

endpackage

// File: rtl/nand_quad_tester_settle_timer.sv
// Loadable settle down-counter; holds at zero and flags it.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = CW'(SETTLE_CYCLES - 1);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nand_quad_tester.sv
// Self-test sequencer for a quad 2-input NAND: drive, settle, sample, accumulate.
// FIRST_FAIL_CAPTURE_EN adds first_fail_step/first_fail_y capture of the first failing sample.
module nand_quad_tester
    import nand_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_GATES-1:0] y_in,
    output logic [NUM_GATES-1:0] a_drv,
    output logic [NUM_GATES-1:0] b_drv,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [ERR_W-1:0]     err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic [1:0]           first_fail_step,
    output logic [NUM_GATES-1:0] first_fail_y
`endif
);

    state_e               state_q, state_d;
    logic [1:0]           step_q, step_d;
    vec_t                 vec_q, vec_d;
    logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 pass_q, pass_d;
    logic [NUM_GATES-1:0] mism;
    logic                 tmr_load, tmr_en, tmr_zero;
    logic                 run_start;

    assign run_start = (state_q == S_IDLE) && start && !abort;
    assign tmr_en    = (state_q == S_DRIVE);
    // The golden value travels with the driven vector, so it always matches the pins.
    assign mism      = y_in ^ vec_q.y;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk   (clk),
        .rst   (rst),
        .load_i(tmr_load),
        .en_i  (tmr_en),
        .zero_o(tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        vec_d       = vec_q;
        fail_mask_d = fail_mask_q;
        err_cnt_d   = err_cnt_q;
        pass_d      = pass_q;
        tmr_load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_start) begin
                    state_d     = S_DRIVE;
                    step_d      = 2'd0;
                    vec_d       = vec_for_step(2'd0);
                    fail_mask_d = '0;
                    err_cnt_d   = '0;
                    pass_d      = 1'b0;
                    tmr_load    = 1'b1;
                end
            end
            S_DRIVE: begin
                if (tmr_zero)
                    state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                fail_mask_d = fail_mask_q | mism;
                err_cnt_d   = err_cnt_q + ERR_W'($countones(mism));
                if (step_q == 2'd3) begin
                    state_d = S_DONE;
                    pass_d  = (fail_mask_d == '0);
                end else begin
                    state_d  = S_DRIVE;
                    step_d   = step_q + 2'd1;
                    vec_d    = vec_for_step(step_d);
                    tmr_load = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
            end
        endcase
        // Abort overrides every transition; partial results stay visible but never pass.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            vec_d    = '0;
            pass_d   = 1'b0;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            vec_q       <= '0;
            fail_mask_q <= '0;
            err_cnt_q   <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            vec_q       <= vec_d;
            fail_mask_q <= fail_mask_d;
            err_cnt_q   <= err_cnt_d;
            pass_q      <= pass_d;
        end
    end

    assign a_drv     = vec_q.a;
    assign b_drv     = vec_q.b;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign err_cnt   = err_cnt_q;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [1:0]           ff_step_q;
    logic [NUM_GATES-1:0] ff_y_q;

    // An all-clear fail_mask means no earlier sample of this run has failed.
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            ff_step_q <= '0;
            ff_y_q    <= '0;
        end else if (state_q == S_SAMPLE && mism != '0 && fail_mask_q == '0) begin
            ff_step_q <= step_q;
            ff_y_q    <= y_in;
        end
    end

    assign first_fail_step = ff_step_q;
    assign first_fail_y    = ff_y_q;
`endif

endmodule
